cpu_controller: RTL and testbench
=================================

# cpu_controller

Multi-cycle control unit for the 16-bit Tetris CPU, sitting on the other end of the datapath's control interface. It fetches instruction words from unified memory, holds them in an instruction register that drives the datapath's `instrMem` input, and sequences the datapath's `controlbits[10:0]` for each instruction. It also latches the datapath's `psr` flags and resolves branch conditions.

## Interface
- `WIDTH`, 16, data and instruction word width.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mem_rdata`  in  16  synchronous-read memory data, valid one cycle after the address is presented.
- `psr`  in  5  ALU flags from the datapath: [0] C, [1] L, [2] F, [3] Z, [4] N.
- `ir`  out  16  instruction register, wired to the datapath's `instrMem`.
- `controlbits`  out  11  [3:0] alucode, [4] alu_a=1, [5] alu_a=imm, [6] alu_b=pc, [7] writeback=memory, [8] pc_wr, [9] regwrite, [10] mem_we.
- `addr_sel`  out  1  memory address mux select: 0 = PC, 1 = ALU result.
- `jump`  out  1  branch condition true; asserted only in EXEC of a Bcond or Jcond.
- `halted`  out  1  high while in HALT.

## Operation
- **Instruction fields:**
  - op = ir[15:12], rdest = ir[11:8], ext = ir[7:4], rsrc = ir[3:0], imm = ir[7:0].
- **Alucode values:**
  - ADD 0000, SUB 0001 (a−b), AND 0010, OR 0011, XOR 0100.
  - MOVA 0101 (result=a), MOVB 0110 (result=b), CMP 0111 (flags only).
- **States:** FETCH, DECODE, EXEC, MEM, WB, PCINC, HALT. Outputs are Moore, decoded from state and ir.
- **FETCH:** addr_sel=0, all controlbits 0 → DECODE.
- **DECODE:** ir ← mem_rdata, controlbits 0 → EXEC.
- **EXEC, by opcode:**
  - R-type (op 0000): ext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV (MOVB), 1011 CMP. Sets regwrite, except CMP. → PCINC.
  - Immediate forms: op 0101 ADDI, 1001 SUBI, 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI (MOVA), 1011 CMPI. Sets bit[5]. → PCINC.
  - LOAD (op 0100, ext 0000): MOVB (address = rsrc), addr_sel=1. → MEM.
  - STOR (op 0100, ext 0100): MOVA with bit[5]=0 (address = rdest), addr_sel=1, mem_we=1. Store data is rsrc. → PCINC.
  - Bcond (op 1100): condition taken → bits[5,6] set, ADD, pc_wr=1 (PC ← PC + sign-extended imm), → FETCH. Not taken → PCINC.
  - Jcond (op 0100, ext 1100): condition taken → MOVB, pc_wr=1 (PC ← rsrc), → FETCH. Not taken → PCINC.
  - HALT (op 1111): → HALT.
  - Any other encoding: NOP, → PCINC.
- **MEM:** holds LOAD's EXEC controls with mem_we=0 → WB.
- **WB:** bit[7]=1, regwrite=1, addr_sel=1 → PCINC.
- **PCINC:** bits[4,6] set, ADD, pc_wr=1 (PC ← PC+1) → FETCH.
- **Flag register:** updated from `psr` on the EXEC edge of ADD, SUB, CMP, ADDI, SUBI and CMPI only.
- **Conditions (rdest field):**
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N.
  - 1110 UC always; all others never.
- **Reset:**
  - State ← FETCH, ir ← 0, flags ← 0. controlbits=0, addr_sel=0, jump=0, halted=0.
  - An instruction in progress is abandoned. No regwrite, pc_wr or mem_we is asserted in the cycle after reset deasserts.

## Timing
- Cycles per instruction, FETCH to next FETCH:
  - ALU, immediate and STOR: 4.
  - LOAD: 6.
  - Branch taken: 3. Branch not taken: 4.
- ir is stable from the edge ending DECODE until the next DECODE edge.
- mem_we is a single-cycle pulse. regwrite and pc_wr never assert in the same cycle.
- Flags used by a branch are those latched by the most recent flag-setting instruction. A flag-setting instruction directly before a branch is visible to it.

## Configuration
- **`CPU_CTRL_HALT_EN` defined:** op 1111 enters HALT.
  - HALT holds all controlbits at 0 and halted=1 until reset.
- **`CPU_CTRL_HALT_EN` undefined:** op 1111 decodes as a NOP (→ PCINC).
  - HALT state and `halted` logic are removed; `halted` is tied to 0.

## Test plan
- **ADD:** ir = 0x0251 (ADD r2,r1). Required EXEC controlbits = 0x200, PCINC controlbits = 0x150, next FETCH 4 cycles after the previous FETCH.
- **LOAD:** ir = 0x4307. Required EXEC controlbits = 0x006 with addr_sel=1, MEM equal to EXEC, WB = 0x286, then PCINC = 0x150.
- **Bcond:**
  - CMP with psr Z=1, then 0xC0FE (BEQ −2): required EXEC controlbits = 0x160, jump=1, next state FETCH.
  - Repeat with Z=0: required jump=0, PCINC follows.
- **STOR:** ir = 0x4543. Required EXEC controlbits = 0x405, addr_sel=1, mem_we for exactly one cycle.
- **Reset mid-operation:** reset low during WB of a LOAD. Required next cycle: FETCH, ir = 0, controlbits = 0, flags cleared.
- **HALT:** ir = 0xF000. With `CPU_CTRL_HALT_EN` defined, required halted=1 and controlbits=0 for 20 cycles. Without it, PCINC follows.

Source files
------------

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: control-side bus between the controller and the datapath/memory.
// The master is the controller and the slave is the datapath side.
interface cpu_controller_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] mem_rdata;
   logic [4:0]       psr;
   logic [WIDTH-1:0] ir;
   logic [10:0]      controlbits;
   logic             addr_sel;
   logic             jump;
   logic             halted;

   modport master (
      input  mem_rdata, psr,
      output ir, controlbits, addr_sel, jump, halted
   );

   modport slave (
      output mem_rdata, psr,
      input  ir, controlbits, addr_sel, jump, halted
   );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB/PCINC sequencer for the 16-bit Tetris CPU.
// Define CPU_CTRL_HALT_EN to make op 1111 enter a sticky HALT state; otherwise it decodes as a NOP.
module cpu_controller #(
   parameter int WIDTH = 16
) (
   input logic              clock,
   input logic              reset,
   cpu_controller_if.master bus
);
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_MOVA = 4'b0101;
   localparam logic [3:0] ALU_MOVB = 4'b0110;
   localparam logic [3:0] ALU_CMP  = 4'b0111;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      PCINC
`ifdef CPU_CTRL_HALT_EN
      , HALT
`endif
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] ir_q;
   logic [4:0]       flags;
   logic [3:0]       op;
   logic [3:0]       rdest;
   logic [3:0]       ext;
   logic [4:0]       alu_dec;
   logic [10:0]      exec_ctrl;
   logic             exec_addr_sel;
   logic             is_load;
   logic             is_branch;
   logic             is_halt;
   logic             sets_flags;
   logic             cond_true;
   logic [10:0]      ctrl;
   logic             addr_sel;
   logic             jump;
   logic             halted;
   logic             unused_flag;

   assign op    = ir_q[15:12];
   assign rdest = ir_q[11:8];
   assign ext   = ir_q[7:4];

   // The F flag is latched with the rest of psr but no condition reads it.
   assign unused_flag = flags[2];

   // Shared ALU opcode table: the R-type ext field and the immediate opcode use the same codes.
   function automatic logic [4:0] alu_decode(input logic [3:0] code, input logic imm_form);
      case (code)
         4'b0101: alu_decode = {1'b1, ALU_ADD};
         4'b1001: alu_decode = {1'b1, ALU_SUB};
         4'b0001: alu_decode = {1'b1, ALU_AND};
         4'b0010: alu_decode = {1'b1, ALU_OR};
         4'b0011: alu_decode = {1'b1, ALU_XOR};
         4'b1101: alu_decode = {1'b1, (imm_form ? ALU_MOVA : ALU_MOVB)};
         4'b1011: alu_decode = {1'b1, ALU_CMP};
         default: alu_decode = 5'b0;
      endcase
   endfunction

   always_comb begin
      case (rdest)
         4'b0000: cond_true = flags[3];
         4'b0001: cond_true = ~flags[3];
         4'b0010: cond_true = flags[0];
         4'b0011: cond_true = ~flags[0];
         4'b0100: cond_true = flags[1];
         4'b0101: cond_true = ~flags[1];
         4'b0110: cond_true = flags[4];
         4'b0111: cond_true = ~flags[4];
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   // EXEC-state controls for the instruction held in ir; MEM and WB reuse them for LOAD.
   always_comb begin
      alu_dec       = alu_decode((op == 4'b0000) ? ext : op, op != 4'b0000);
      exec_ctrl     = '0;
      exec_addr_sel = 1'b0;
      is_load       = 1'b0;
      is_branch     = 1'b0;
      is_halt       = 1'b0;
      sets_flags    = 1'b0;
      case (op)
         4'b0000, 4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1011: begin
            if (alu_dec[4]) begin
               exec_ctrl[3:0] = alu_dec[3:0];
               exec_ctrl[5]   = (op != 4'b0000);
               exec_ctrl[9]   = (alu_dec[3:0] != ALU_CMP);
               sets_flags     = (alu_dec[3:0] inside {ALU_ADD, ALU_SUB, ALU_CMP});
            end
         end
         4'b0100: begin
            case (ext)
               4'b0000: begin
                  exec_ctrl[3:0] = ALU_MOVB;
                  exec_addr_sel  = 1'b1;
                  is_load        = 1'b1;
               end
               4'b0100: begin
                  exec_ctrl[3:0] = ALU_MOVA;
                  exec_ctrl[10]  = 1'b1;
                  exec_addr_sel  = 1'b1;
               end
               4'b1100: begin
                  is_branch = 1'b1;
                  if (cond_true) begin
                     exec_ctrl[3:0] = ALU_MOVB;
                     exec_ctrl[8]   = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         4'b1100: begin
            is_branch = 1'b1;
            if (cond_true) begin
               exec_ctrl[3:0] = ALU_ADD;
               exec_ctrl[5]   = 1'b1;
               exec_ctrl[6]   = 1'b1;
               exec_ctrl[8]   = 1'b1;
            end
         end
`ifdef CPU_CTRL_HALT_EN
         4'b1111: is_halt = 1'b1;
`endif
         default: ;
      endcase
   end

   always_comb begin
      next_state = state;
      ctrl       = '0;
      addr_sel   = 1'b0;
      jump       = 1'b0;
      halted     = 1'b0;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: next_state = EXEC;
         EXEC: begin
            ctrl     = exec_ctrl;
            addr_sel = exec_addr_sel;
            jump     = is_branch & cond_true;
            if (is_load)
               next_state = MEM;
            else if (is_branch && cond_true)
               next_state = FETCH;
`ifdef CPU_CTRL_HALT_EN
            else if (is_halt)
               next_state = HALT;
`endif
            else
               next_state = PCINC;
         end
         MEM: begin
            ctrl       = exec_ctrl & ~11'h400;
            addr_sel   = 1'b1;
            next_state = WB;
         end
         WB: begin
            ctrl       = exec_ctrl | 11'h280;
            addr_sel   = 1'b1;
            next_state = PCINC;
         end
         PCINC: begin
            ctrl       = 11'h150;
            next_state = FETCH;
         end
`ifdef CPU_CTRL_HALT_EN
         HALT: halted = 1'b1;
`endif
         default: next_state = FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= FETCH;
         ir_q  <= '0;
         flags <= '0;
      end else begin
         state <= next_state;
         if (state == DECODE)
            ir_q <= bus.mem_rdata;
         if (state == EXEC && sets_flags)
            flags <= bus.psr;
      end
   end

   assign bus.ir          = ir_q;
   assign bus.controlbits = ctrl;
   assign bus.addr_sel    = addr_sel;
   assign bus.jump        = jump;
   assign bus.halted      = halted;

   logic unused_is_halt;
   assign unused_is_halt = is_halt;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed and randomized checks of cpu_controller against an instruction-level model.
// Every cycle's expected outputs are queued by the driver and compared on the falling clock edge.
module tb_cpu_controller;
   typedef struct packed {
      logic [10:0] ctrl;
      logic        asel;
      logic        jmp;
      logic        hlt;
      logic [15:0] irv;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   exp_t expq[$];
   exp_t cur;
   logic [4:0]  m_flags;
   logic [15:0] m_ir;

   cpu_controller_if #(.WIDTH(16)) bus ();

   cpu_controller #(.WIDTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      if (expq.size() > 0) begin
         cur = expq.pop_front();
         checkOutput("controlbits", {5'b0, bus.controlbits}, {5'b0, cur.ctrl});
         checkOutput("addr_sel", {15'b0, bus.addr_sel}, {15'b0, cur.asel});
         checkOutput("jump", {15'b0, bus.jump}, {15'b0, cur.jmp});
         checkOutput("halted", {15'b0, bus.halted}, {15'b0, cur.hlt});
         checkOutput("ir", bus.ir, cur.irv);
      end
   end

   task automatic pushExp(input logic [10:0] c, input logic a, input logic j, input logic h, input logic [15:0] i);
      exp_t e;
      e.ctrl = c;
      e.asel = a;
      e.jmp  = j;
      e.hlt  = h;
      e.irv  = i;
      expq.push_back(e);
   endtask

   task automatic applyStimulus(input logic [15:0] instr, input logic [4:0] p);
      bus.mem_rdata = instr;
      bus.psr       = p;
   endtask

   task automatic runQueued();
      int n;
      n = expq.size();
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Mnemonic table: ALU code for an R-type ext or immediate opcode, -1 if not an ALU op.
   function automatic int aluOf(input logic [3:0] code, input bit immForm);
      case (code)
         4'h5: return 0;
         4'h9: return 1;
         4'h1: return 2;
         4'h2: return 3;
         4'h3: return 4;
         4'hD: return immForm ? 5 : 6;
         4'hB: return 7;
         default: return -1;
      endcase
   endfunction

   function automatic bit taken(input logic [3:0] cond, input logic [4:0] f);
      bit v;
      if (cond == 4'd14) return 1'b1;
      if (cond > 4'd7) return 1'b0;
      case (cond / 2)
         0: v = f[3];
         1: v = f[0];
         2: v = f[1];
         default: v = f[4];
      endcase
      return (cond % 2 == 1) ? !v : v;
   endfunction

   // Queue the whole cycle-by-cycle trace of one instruction and advance the model's ir/flags.
   task automatic modelInstr(input logic [15:0] instr, input logic [4:0] p);
      logic [3:0] op;
      logic [3:0] ext;
      int a;
      op  = instr[15:12];
      ext = instr[7:4];
      a   = (op == 4'h0) ? aluOf(ext, 1'b0) : aluOf(op, 1'b1);
      pushExp(11'h0, 1'b0, 1'b0, 1'b0, m_ir);
      pushExp(11'h0, 1'b0, 1'b0, 1'b0, m_ir);
      if (a >= 0) begin
         pushExp(11'(a) | (op != 4'h0 ? 11'h020 : 11'h0) | (a != 7 ? 11'h200 : 11'h0), 1'b0, 1'b0, 1'b0, instr);
         pushExp(11'h150, 1'b0, 1'b0, 1'b0, instr);
         if (a == 0 || a == 1 || a == 7)
            m_flags = p;
      end else if (op == 4'h4 && ext == 4'h0) begin
         pushExp(11'h006, 1'b1, 1'b0, 1'b0, instr);
         pushExp(11'h006, 1'b1, 1'b0, 1'b0, instr);
         pushExp(11'h286, 1'b1, 1'b0, 1'b0, instr);
         pushExp(11'h150, 1'b0, 1'b0, 1'b0, instr);
      end else if (op == 4'h4 && ext == 4'h4) begin
         pushExp(11'h405, 1'b1, 1'b0, 1'b0, instr);
         pushExp(11'h150, 1'b0, 1'b0, 1'b0, instr);
      end else if (op == 4'hC || (op == 4'h4 && ext == 4'hC)) begin
         if (taken(instr[11:8], m_flags)) begin
            pushExp(op == 4'hC ? 11'h160 : 11'h106, 1'b0, 1'b1, 1'b0, instr);
         end else begin
            pushExp(11'h0, 1'b0, 1'b0, 1'b0, instr);
            pushExp(11'h150, 1'b0, 1'b0, 1'b0, instr);
         end
      end else begin
         pushExp(11'h0, 1'b0, 1'b0, 1'b0, instr);
         pushExp(11'h150, 1'b0, 1'b0, 1'b0, instr);
      end
      m_ir = instr;
   endtask

   function automatic logic [15:0] randInstr();
      logic [15:0] w;
      logic [3:0]  c;
      w = 16'($urandom);
      case ($urandom_range(0, 6))
         0: c = 4'h5;
         1: c = 4'h9;
         2: c = 4'h1;
         3: c = 4'h2;
         4: c = 4'h3;
         5: c = 4'hD;
         default: c = 4'hB;
      endcase
      case ($urandom_range(0, 8))
         0, 1: begin w[15:12] = 4'h0; w[7:4] = c; end
         2:    w[15:12] = c;
         3:    begin w[15:12] = 4'h4; w[7:4] = 4'h0; end
         4:    begin w[15:12] = 4'h4; w[7:4] = 4'h4; end
         5:    w[15:12] = 4'hC;
         6:    begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
         7:    w[15:12] = 4'h0;
         default: ;
      endcase
`ifdef CPU_CTRL_HALT_EN
      if (w[15:12] == 4'hF)
         w[15:12] = 4'hE;
`endif
      return w;
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      applyStimulus(16'h0000, 5'h00);
      @(posedge clock);
      #1;
      // Reset state.
      pushExp(11'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
      pushExp(11'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
      runQueued();
      reset = 1'b1;

      // ADD r2,r1.
      applyStimulus(16'h0251, 5'h00);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
      pushExp(11'h200, 1'b0, 1'b0, 1'b0, 16'h0251);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h0251);
      runQueued();

      // LOAD.
      applyStimulus(16'h4307, 5'h1F);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0251);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0251);
      pushExp(11'h006, 1'b1, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h006, 1'b1, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h286, 1'b1, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h4307);
      runQueued();

      // CMP with Z=1, then BEQ -2 taken.
      applyStimulus(16'h01B2, 5'h08);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h007, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h01B2);
      runQueued();
      applyStimulus(16'hC0FE, 5'h00);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h160, 1'b0, 1'b1, 1'b0, 16'hC0FE);
      runQueued();

      // CMP with Z=0, then BEQ -2 not taken.
      applyStimulus(16'h01B2, 5'h00);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      pushExp(11'h007, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h01B2);
      runQueued();
      applyStimulus(16'hC0FE, 5'h1F);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      runQueued();

      // STOR.
      applyStimulus(16'h4543, 5'h1F);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hC0FE);
      pushExp(11'h405, 1'b1, 1'b0, 1'b0, 16'h4543);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h4543);
      runQueued();

      // Set every flag, then reset during WB of a LOAD; BCC must see cleared flags.
      applyStimulus(16'h01B2, 5'h1F);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h4543);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h4543);
      pushExp(11'h007, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'h01B2);
      runQueued();
      applyStimulus(16'h4307, 5'h1F);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h01B2);
      pushExp(11'h006, 1'b1, 1'b0, 1'b0, 16'h4307);
      pushExp(11'h006, 1'b1, 1'b0, 1'b0, 16'h4307);
      repeat (4) @(posedge clock);
      #1;
      pushExp(11'h286, 1'b1, 1'b0, 1'b0, 16'h4307);
      reset = 1'b0;
      runQueued();
      reset = 1'b1;
      applyStimulus(16'hC302, 5'h00);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'h0000);
      pushExp(11'h160, 1'b0, 1'b1, 1'b0, 16'hC302);
      runQueued();

      // Randomized instruction stream against the model.
      m_flags = 5'h00;
      m_ir    = 16'hC302;
      for (int k = 0; k < 400; k++) begin
         logic [15:0] ins;
         logic [4:0]  p;
         ins = randInstr();
         p   = 5'($urandom_range(0, 31));
         applyStimulus(ins, p);
         modelInstr(ins, p);
         runQueued();
      end

      // HALT encoding.
      applyStimulus(16'hF000, 5'h00);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, m_ir);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, m_ir);
      pushExp(11'h000, 1'b0, 1'b0, 1'b0, 16'hF000);
`ifdef CPU_CTRL_HALT_EN
      for (int k = 0; k < 20; k++)
         pushExp(11'h000, 1'b0, 1'b0, 1'b1, 16'hF000);
`else
      pushExp(11'h150, 1'b0, 1'b0, 1'b0, 16'hF000);
`endif
      runQueued();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
